// File: rtl/dtu_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// dtu_tx_scheduler_pkg : shared state encoding, frame width and width helpers
// Rev 1.0
// ============================================================================
package dtu_tx_scheduler_pkg;

  localparam int FRAME_W_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    GAP    = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Counter widths never collapse to zero bits, even for degenerate limits.
  function automatic int width_of(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dtu_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// dtu_tx_scheduler_if : requester / tx / rx signal bundle of the scheduler
// Rev 1.0
// ============================================================================
interface dtu_tx_scheduler_if
  import dtu_tx_scheduler_pkg::*;
#(
  parameter int N       = 4,
  parameter int FRAME_W = FRAME_W_DEFAULT
);

  logic [N-1:0]         req;
  logic [N*FRAME_W-1:0] req_data;
  logic [N-1:0]         grant;
  logic [N-1:0]         done;
  logic [N-1:0]         err;
  logic                 tx_start;
  logic [FRAME_W-1:0]   tx_pi;
  logic                 rx_ready;
  logic                 rx_valid;
  logic                 busy;

  // Scheduler side
  modport master (
    input  req, req_data, rx_ready, rx_valid,
    output grant, done, err, tx_start, tx_pi, busy
  );

  // Requester / link side
  modport slave (
    output req, req_data, rx_ready, rx_valid,
    input  grant, done, err, tx_start, tx_pi, busy
  );

endinterface
`default_nettype wire

// File: rtl/dtu_tx_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// dtu_tx_scheduler_rr_arbiter : combinational round-robin pick, searching
// upward from ptr and wrapping modulo N
// Rev 1.0
// ============================================================================
module dtu_tx_scheduler_rr_arbiter
  import dtu_tx_scheduler_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = width_of(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_any
);

  logic [IDX_W:0]   pos_wide;
  logic [IDX_W-1:0] pos;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    pick_any = 1'b0;
    pos_wide = '0;
    pos      = '0;
    for (int k = 0; k < N; k++) begin
      // One extra bit so ptr+k never overflows before the modulo-N wrap
      pos_wide = {1'b0, ptr} + (IDX_W+1)'(k);
      if (pos_wide >= (IDX_W+1)'(N)) begin
        pos_wide = pos_wide - (IDX_W+1)'(N);
      end
      pos = pos_wide[IDX_W-1:0];
      if (!pick_any && req[pos]) begin
        pick_any  = 1'b1;
        pick_idx  = pos;
        pick[pos] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dtu_tx_scheduler.sv
`default_nettype none
// ============================================================================
// dtu_tx_scheduler : round-robin sharing of one tx serial link between N frame
// requesters, with rx-verdict driven retransmission and done/err reporting
// Rev 1.0
// ============================================================================
module dtu_tx_scheduler
  import dtu_tx_scheduler_pkg::*;
#(
  parameter int N          = 4,
  parameter int FRAME_W    = FRAME_W_DEFAULT,
  parameter int TIMEOUT    = 2000000,
  parameter int MAX_RETRY  = 2,
  parameter int GAP_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  dtu_tx_scheduler_if.master  bus
);

  localparam int IDX_W   = width_of(N);
  localparam int CNT_W   = width_of(TIMEOUT + 1);
  localparam int RETRY_W = width_of(MAX_RETRY + 1);
  localparam int GAP_W   = width_of(GAP_CYCLES + 1);

  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [N-1:0]         grant_q, grant_d;
  logic [N-1:0]         done_q, done_d;
  logic [N-1:0]         err_q, err_d;
  logic                 tx_start_q, tx_start_d;
  logic [FRAME_W-1:0]   tx_pi_q, tx_pi_d;
  logic                 busy_q, busy_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 rx_prev_q, rx_prev_d;

  logic [N-1:0]         pick;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [FRAME_W-1:0]   frame_slice [N];
  logic [N-1:0]         win_onehot;
  logic [IDX_W-1:0]     ptr_next;
  logic                 rx_rise;
  logic                 timeout_hit;

  dtu_tx_scheduler_rr_arbiter #(
    .N (N)
  ) u_arb (
    .req      (bus.req),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign frame_slice[gi] = bus.req_data[gi*FRAME_W +: FRAME_W];
  end

  assign win_onehot  = ONE_HOT0 << win_q;
  assign ptr_next    = (win_q == IDX_W'(N - 1)) ? '0 : win_q + 1'b1;
  assign rx_rise     = bus.rx_ready & ~rx_prev_q;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    grant_d    = '0;
    done_d     = '0;
    err_d      = '0;
    tx_start_d = 1'b0;
    tx_pi_d    = tx_pi_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    retry_d    = retry_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick;
          tx_pi_d = frame_slice[pick_idx];
          win_d   = pick_idx;
          retry_d = '0;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start_d = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // An rx edge takes precedence over a coincident timeout
        if (rx_rise && bus.rx_valid) begin
          done_d  = win_onehot;
          ptr_d   = ptr_next;
          gap_d   = '0;
          state_d = GAP;
        end else if (rx_rise || timeout_hit) begin
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = LAUNCH;
          end else begin
            err_d   = win_onehot;
            ptr_d   = ptr_next;
            gap_d   = '0;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Zero during LAUNCH, so WAIT compares against the level seen at launch
    // and a line already high from an earlier frame is not taken as an edge.
    rx_prev_d = (state_d == LAUNCH) ? 1'b0 : bus.rx_ready;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= '0;
      tx_start_q <= 1'b0;
      tx_pi_q    <= '0;
      busy_q     <= 1'b0;
      ptr_q      <= '0;
      win_q      <= '0;
      retry_q    <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      rx_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tx_start_q <= tx_start_d;
      tx_pi_q    <= tx_pi_d;
      busy_q     <= busy_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      retry_q    <= retry_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      rx_prev_q  <= rx_prev_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_pi    = tx_pi_q;
  assign bus.busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dtu_tx_scheduler.sv
`default_nettype none
// ============================================================================
// tb_dtu_tx_scheduler : vector table plus directed sequences for the scheduler
// Rev 1.0
// ============================================================================
module tb_dtu_tx_scheduler;

  localparam int N         = 4;
  localparam int FRAME_W   = 10;
  localparam int TIMEOUT   = 150;
  localparam int MAX_RETRY = 2;
  localparam int GAP       = 16;

  localparam logic [FRAME_W-1:0] D0 = 10'h155;
  localparam logic [FRAME_W-1:0] D1 = 10'h0F3;
  localparam logic [FRAME_W-1:0] D2 = 10'h2A5;
  localparam logic [FRAME_W-1:0] D3 = 10'h3C1;

  localparam int EV_GRANT = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ERR   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dtu_tx_scheduler_if #(.N(N), .FRAME_W(FRAME_W)) bus ();

  dtu_tx_scheduler #(
    .N          (N),
    .FRAME_W    (FRAME_W),
    .TIMEOUT    (TIMEOUT),
    .MAX_RETRY  (MAX_RETRY),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.req_data = {D3, D2, D1, D0};

  typedef struct {
    int                 kind;
    logic [N-1:0]       vec;
    logic [FRAME_W-1:0] data;
  } ev_t;

  typedef struct {
    logic [N-1:0]       set;
    logic [N-1:0]       clr;
    int                 idx;
    logic [FRAME_W-1:0] data;
    int                 delay;
    bit                 lat;
  } vec_t;

  ev_t  exp_q[$];
  vec_t vecs[7];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_start = 0;
  int n_done = 0;
  int last_grant_cyc = -1;
  int last_done_cyc = -1;
  int last_err_cyc = -1;
  logic [FRAME_W-1:0] cur_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic push_ev(input int kind, input int idx, input logic [FRAME_W-1:0] data);
    ev_t e;
    logic [N-1:0] one;
    one    = 1;
    e.kind = kind;
    e.vec  = one << idx;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input logic [N-1:0] vec, input logic [FRAME_W-1:0] pi);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: got kind %0d vec 0x%0h expected no event", kind, vec);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", 32'(kind), 32'(e.kind));
      check("sb_vec", 32'(vec), 32'(e.vec));
      if (kind == EV_GRANT) begin
        check("sb_grant_tx_pi", 32'(pi), 32'(e.data));
        cur_data = e.data;
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.grant != '0) begin
      sb_pop(EV_GRANT, bus.grant, bus.tx_pi);
      last_grant_cyc = cyc;
    end
    if (bus.done != '0) begin
      sb_pop(EV_DONE, bus.done, bus.tx_pi);
      last_done_cyc = cyc;
      n_done++;
    end
    if (bus.err != '0) begin
      sb_pop(EV_ERR, bus.err, bus.tx_pi);
      last_err_cyc = cyc;
    end
    if (bus.tx_start) begin
      n_start++;
      check("tx_pi_at_start", 32'(bus.tx_pi), 32'(cur_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output int s);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.tx_start) begin
        s = cyc;
        return;
      end
    end
    s = cyc;
    fail("wait_tx_start");
  endtask

  task automatic wait_idle(output int b);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        b = cyc;
        return;
      end
    end
    b = cyc;
    fail("wait_idle");
  endtask

  task automatic pulse_rx(input logic valid);
    bus.rx_ready = 1'b1;
    bus.rx_valid = valid;
    tick();
    bus.rx_ready = 1'b0;
    bus.rx_valid = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_grant"}, 32'(bus.grant), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
    check({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
    check({tag, "_tx_pi"}, 32'(bus.tx_pi), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, s2, s3, b, t, r, n0;

    //            set      clr      idx data delay lat
    vecs[0] = '{4'b1011, 4'b0000, 0, D0, 5,   1'b1};
    vecs[1] = '{4'b0000, 4'b0000, 1, D1, 7,   1'b0};
    vecs[2] = '{4'b0000, 4'b0000, 3, D3, 3,   1'b0};
    vecs[3] = '{4'b0000, 4'b1011, 0, D0, 4,   1'b0};
    vecs[4] = '{4'b0100, 4'b0100, 2, D2, 100, 1'b1};
    vecs[5] = '{4'b0110, 4'b0010, 1, D1, 6,   1'b1};
    vecs[6] = '{4'b0000, 4'b0100, 2, D2, 8,   1'b0};

    bus.req      = '0;
    bus.rx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    rst          = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");

    // Round-robin rotation, single requester, fresh requests from idle
    for (int i = 0; i < 7; i++) begin
      int t_req, vs, vb;
      push_ev(EV_GRANT, vecs[i].idx, vecs[i].data);
      push_ev(EV_DONE, vecs[i].idx, vecs[i].data);
      bus.req = bus.req | vecs[i].set;
      t_req   = cyc;
      wait_start(vs);
      if (vecs[i].lat) check("req_to_grant", 32'(last_grant_cyc), 32'(t_req + 1));
      check("grant_to_start", 32'(vs), 32'(last_grant_cyc + 1));
      bus.req = bus.req & ~vecs[i].clr;
      repeat (vecs[i].delay) tick();
      pulse_rx(1'b1);
      wait_idle(vb);
      check("gap_length", 32'(vb), 32'(last_done_cyc + GAP));
    end

    // Invalid verdict then valid verdict: one retransmission, then done
    n0 = n_start;
    push_ev(EV_GRANT, 1, D1);
    push_ev(EV_DONE, 1, D1);
    bus.req = 4'b0010;
    wait_start(s);
    bus.req = '0;
    repeat (10) tick();
    pulse_rx(1'b0);
    wait_start(s2);
    check("retry_relaunch", 32'(s2), 32'(s + 12));
    repeat (10) tick();
    pulse_rx(1'b1);
    wait_idle(b);
    check("retry_start_count", 32'(n_start - n0), 32'd2);

    // No rx response at all: three attempts TIMEOUT+1 apart, then err
    n0 = n_start;
    push_ev(EV_GRANT, 0, D0);
    push_ev(EV_ERR, 0, D0);
    bus.req = 4'b0001;
    wait_start(s);
    bus.req = '0;
    wait_start(s2);
    wait_start(s3);
    check("timeout_spacing_1", 32'(s2 - s), 32'(TIMEOUT + 1));
    check("timeout_spacing_2", 32'(s3 - s2), 32'(TIMEOUT + 1));
    wait_idle(b);
    check("timeout_err_cycle", 32'(last_err_cyc), 32'(s3 + TIMEOUT));
    check("timeout_start_count", 32'(n_start - n0), 32'd3);

    // rx_ready already high at launch: only a later rising edge completes
    push_ev(EV_GRANT, 3, D3);
    push_ev(EV_DONE, 3, D3);
    bus.req      = 4'b1000;
    bus.rx_ready = 1'b1;
    bus.rx_valid = 1'b1;
    n0 = n_done;
    wait_start(s);
    bus.req = '0;
    repeat (20) tick();
    check("stale_level_ignored", 32'(n_done - n0), 32'd0);
    bus.rx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    tick();
    tick();
    bus.rx_ready = 1'b1;
    bus.rx_valid = 1'b1;
    r = cyc;
    tick();
    bus.rx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    wait_idle(b);
    check("stale_done_cycle", 32'(last_done_cyc), 32'(r + 1));

    // Rising edge in the same cycle as the timeout: edge wins
    n0 = n_start;
    push_ev(EV_GRANT, 2, D2);
    push_ev(EV_DONE, 2, D2);
    bus.req = 4'b0100;
    wait_start(s);
    bus.req = '0;
    repeat (TIMEOUT - 1) tick();
    bus.rx_ready = 1'b1;
    bus.rx_valid = 1'b1;
    r = cyc;
    tick();
    bus.rx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    wait_idle(b);
    check("edge_vs_timeout_done", 32'(last_done_cyc), 32'(r + 1));
    check("edge_vs_timeout_starts", 32'(n_start - n0), 32'd1);

    // Reset mid-WAIT: transaction dropped, pointer back to 0
    push_ev(EV_GRANT, 2, D2);
    bus.req = 4'b0100;
    wait_start(s);
    bus.req = 4'b1010;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    t = cyc;
    exp_q.delete();
    push_ev(EV_GRANT, 1, D1);
    push_ev(EV_DONE, 1, D1);
    @(negedge clk);
    check_outputs_zero("reset_mid_wait");
    wait_start(s);
    check("reset_to_grant", 32'(last_grant_cyc), 32'(t + 1));
    bus.req = '0;
    repeat (5) tick();
    pulse_rx(1'b1);
    wait_idle(b);

    repeat (5) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
